uart_rx_buffered: RTL and testbench
===================================

// Module: uart_rx_buffered
// PURPOSE
//  Receive side of the SoC 8N1 UART, taking the i_uart_rx pin. Oversamples the line at 16x baud
//  and majority-votes each bit. Checks the stop bit, then pushes good bytes into a small FIFO.
//  The FIFO drains over a valid/ready handshake to the peripheral register bank on clk_core.
// PARAMETERS
//  CLK_FREQ_HZ  50_000_000  core clock frequency
//  BAUD         115200      line rate
//  FIFO_DEPTH   16          byte entries, power of two, >=2
// PORTS
//  clk         in   1               core clock, all logic on rising edge
//  rstn        in   1               asynchronous active-low reset
//  i_uart_rx   in   1               raw serial line, idle high, asynchronous to clk
//  o_data      out  8               FIFO head byte, valid only while o_valid
//  o_valid     out  1               FIFO not empty
//  i_ready     in   1               consumer accepts head when o_valid & i_ready
//  o_level     out  $clog2(D)+1     current FIFO occupancy, 0..FIFO_DEPTH
//  o_frame_err out  1               1-cycle pulse: stop bit sampled low, byte dropped
//  o_overrun   out  1               1-cycle pulse: good byte arrived with FIFO full, byte dropped
// BEHAVIOUR
//  - Reset (async assert, sync release): FSM=IDLE, FIFO empty.
//    o_valid=0, o_level=0, o_data=0, o_frame_err=0, o_overrun=0; sync flops preset to 1.
//  - Input: 2-flop synchronizer. All logic uses the synced value rx_s.
//  - Tick gen: DIV=(CLK_FREQ_HZ+8*BAUD)/(16*BAUD), rounded. Counter 0..DIV-1 gives a 1-clk tick.
//    Counter is held at 0 in IDLE. Elaboration error if DIV<2.
//  - Sample counter sc 0..15 counts ticks within a bit. Bit value = majority of rx_s at sc=7,8,9.
//    Decision is made at sc=9.
//  - FSM:
//    IDLE : on falling edge of rx_s (prev 1, now 0) -> START; clear sc, clear tick counter.
//    START: at sc=9 majority 0 -> DATA, bit idx=0. Majority 1 = glitch -> IDLE, no pulse.
//    DATA : at sc=9 shift majority into shreg, LSB first. After bit 7 -> STOP.
//    STOP : at sc=9, majority 1 -> push or overrun. Majority 0 -> o_frame_err pulse.
//           Either way -> IDLE immediately at sc=9 (half-bit early, for resync margin).
//    On frame error the FSM waits in IDLE for rx_s=1 before arming a new falling-edge detect.
//    A break (line held low) therefore yields exactly one o_frame_err.
//  - Push/pop:
//    Push happens in the STOP-decision cycle. Pop when o_valid & i_ready.
//    Simultaneous push and pop with FIFO full: pop frees a slot, push succeeds, no overrun.
//    o_level is unchanged in that case.
//    Simultaneous push and pop with FIFO empty: no pop (o_valid=0); byte is pushed, o_valid=1
//    next cycle.
//  - Latency: a byte is visible on o_valid/o_data 1 clk after the push cycle. First-word
//    fall-through: o_data is registered from the head entry.
//  - Pointers are $clog2(D)+1 bits wide with a wrap bit. full = MSBs differ and rest equal.
//    Pointers wrap naturally.
//  - o_frame_err and o_overrun are never asserted in the same cycle. Neither is sticky;
//    the register bank latches them.
//  - rstn asserted mid-frame aborts the frame: partial byte discarded, no pulses.
// STRUCTURE
//  - uart_pkg:
//    typedef enum logic [1:0] {IDLE,START,DATA,STOP} uart_rx_state_e;
//    localparam OVERSAMPLE=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9.
//  - Sub-module sync_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH):
//    push/pop/full/empty/level, async active-low reset. Reusable by a future UART TX buffer.
//  - Top holds synchronizer, tick gen, sample counter, FSM, shift register.
// TESTING
//  Bench params: CLK_FREQ_HZ=64, BAUD=1 -> DIV=4, 64 clk/bit.
//  1 Send 0xA5 with good stop, i_ready=1
//    -> one push, o_data=0xA5 with o_valid for 1 clk; no pulses.
//  2 i_ready=0, send 17 bytes 0x00..0x10
//    -> o_level reaches 16. 17th byte gives o_overrun pulse, o_level stays 16.
//    -> Draining yields 0x00..0x0F in order.
//  3 Send 0x3C with stop bit driven low
//    -> o_frame_err pulse, o_level unchanged.
//    -> Then hold low 5 bit-times, release, send 0x55: exactly one more o_frame_err, then 0x55.
//  4 Glitch: rx low for 3 ticks in IDLE
//    -> FSM returns to IDLE from START, no push, no pulse.
//  5 FIFO full (16), i_ready=1 in the exact push cycle of byte 17
//    -> no o_overrun, o_level stays 16, byte 17 appears last.
//  6 Deassert rstn during DATA bit 4
//    -> all outputs at reset values. Next full frame 0x81 received correctly.
//    Also check a baud offset of +/-3% for 0xFF/0x00 patterns.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The baud divider and 3-sample majority vote are kept here so a future TX side can reuse them.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + 8 * baud) / (OVERSAMPLE * baud);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; the head entry is presented directly from the
// storage flops, so a written byte is visible the cycle after the push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_check
      $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: 16x oversampling with 3-sample majority vote, stop-bit check,
// and a byte FIFO drained over valid/ready.
//
// state | meaning
// IDLE  | line idle; waits for a falling edge (re-armed only after the line is seen high)
// START | validating start bit at mid-bit; a high vote is treated as a glitch
// DATA  | shifting 8 data bits, LSB first
// STOP  | stop-bit vote at mid-bit: push/overrun if high, frame error if low
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_uart_rx,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_frame_err,
  output logic                          o_overrun
);
  localparam int            DIV         = baud_div(CLK_FREQ_HZ, BAUD);
  localparam int            TW          = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_RELOAD = TW'(DIV - 1);
  localparam logic [3:0]    SC_LO       = 4'(SAMPLE_LO);
  localparam logic [3:0]    SC_MID      = 4'(SAMPLE_MID);
  localparam logic [3:0]    SC_HI       = 4'(SAMPLE_HI);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_rx_buffered: clock too slow for 16x oversampling at this baud");
    end
  endgenerate

  logic           rx_meta;
  logic           rx_s;
  logic           rx_prev;
  uart_rx_state_e state;
  logic [TW-1:0]  tick_cnt;
  logic [3:0]     sc;
  logic           vote_lo;
  logic           vote_mid;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           armed;
  logic           tick;
  logic           decide;
  logic           maj;
  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic           overrun_now;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Tick timer is a down-counter; the terminal count of zero is the tick.
  assign tick        = (state != IDLE) && (tick_cnt == '0);
  assign decide      = tick && (sc == SC_HI);
  assign maj         = majority3(vote_lo, vote_mid, rx_s);
  assign push        = (state == STOP) && decide && maj;
  assign pop         = o_valid & i_ready;
  assign overrun_now = push & fifo_full & ~pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      tick_cnt    <= TICK_RELOAD;
      sc          <= '0;
      vote_lo     <= 1'b1;
      vote_mid    <= 1'b1;
      bit_idx     <= '0;
      shreg       <= '0;
      armed       <= 1'b1;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= overrun_now;
      if (state == IDLE) begin
        tick_cnt <= TICK_RELOAD;
        sc       <= '0;
        if (!armed) begin
          armed <= rx_s;
        end else if (rx_prev && !rx_s) begin
          state <= START;
        end
      end else if (tick) begin
        tick_cnt <= TICK_RELOAD;
        sc       <= sc + 1'b1;
        if (sc == SC_LO)  vote_lo  <= rx_s;
        if (sc == SC_MID) vote_mid <= rx_s;
        if (sc == SC_HI) begin
          case (state)
            START: begin
              if (maj) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                bit_idx <= '0;
              end
            end
            DATA: begin
              shreg   <= {maj, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) state <= STOP;
            end
            STOP: begin
              // Leave half a bit early so the next start edge is never missed.
              state <= IDLE;
              if (!maj) begin
                o_frame_err <= 1'b1;
                armed       <= 1'b0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end else begin
        tick_cnt <= tick_cnt - 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (shreg),
    .pop   (pop),
    .rdata (o_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (o_level)
  );

  assign o_valid = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered at 64 clk per bit (DIV=4). Expected bytes come from a queue
// model of an 8N1 line feeding a 16-entry FIFO; pops are captured on the falling clock edge.
module tb_uart_rx_buffered;
  localparam int BIT_CLKS = 64;
  // Edges from driving the start bit to the stop-bit decision: 2 sync + 1 edge detect + 154 ticks * 4.
  localparam int PUSH_LAT = 619;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       uart_rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic [4:0] level;
  logic       frame_err;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;
  logic [7:0] got_q[$];

  uart_rx_buffered #(
    .CLK_FREQ_HZ (64),
    .BAUD        (1),
    .FIFO_DEPTH  (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_uart_rx   (uart_rx),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_level     (level),
    .o_frame_err (frame_err),
    .o_overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_cnt++;
      if (valid && ready) got_q.push_back(data);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] d, input logic stop_v, input int bc);
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (bc) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 uart_rx = d[i];
      repeat (bc) @(posedge clk);
    end
    #1 uart_rx = stop_v;
    repeat (bc) @(posedge clk);
  endtask

  task automatic line_idle(input int nbits);
    #1 uart_rx = 1'b1;
    repeat (nbits * BIT_CLKS) @(posedge clk);
  endtask

  task automatic drain(output bit timed_out);
    int n = 0;
    @(posedge clk); #1 ready = 1'b1;
    while (valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    timed_out = valid;
    ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp += 3;
    if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid_in_reset: got %b want 0", valid); end
    if (level !== 5'd0) begin n_err++; $display("FAIL reset_level_in_reset: got %0d want 0", level); end
    if (data !== 8'h00) begin n_err++; $display("FAIL reset_data_in_reset: got %h want 00", data); end
    @(posedge clk); #1 rstn = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp += 3;
    if (valid !== 1'b0 || level !== 5'd0) begin n_err++; $display("FAIL reset_after_release: valid %b level %0d want 0/0", valid, level); end
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_single();
    logic v_before, v_at, v_after;
    logic [7:0] d_at;
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    got_q.delete();
    ready = 1'b1;
    fork
      send_byte(8'hA5, 1'b1, BIT_CLKS);
      begin
        @(posedge clk);
        repeat (PUSH_LAT - 1) @(posedge clk);
        @(negedge clk); v_before = valid;
        @(posedge clk); @(negedge clk); v_at = valid; d_at = data;
        @(posedge clk); @(negedge clk); v_after = valid;
      end
    join
    line_idle(1);
    ready = 1'b0;
    n_cmp += 6;
    if (v_before !== 1'b0) begin n_err++; $display("FAIL single_valid_early: got %b want 0", v_before); end
    if (v_at !== 1'b1) begin n_err++; $display("FAIL single_valid_latency: got %b want 1", v_at); end
    if (d_at !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", d_at); end
    if (v_after !== 1'b0) begin n_err++; $display("FAIL single_valid_one_clk: got %b want 0", v_after); end
    if (got_q.size() != 1) begin n_err++; $display("FAIL single_pop_count: got %0d want 1", got_q.size()); end
    if (fe_cnt != fe0 || ov_cnt != ov0) begin n_err++; $display("FAIL single_no_pulses: got fe %0d ov %0d want 0/0", fe_cnt - fe0, ov_cnt - ov0); end
  endtask

  task automatic test_overflow();
    int ov0;
    bit to;
    ov0 = ov_cnt;
    got_q.delete();
    ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, BIT_CLKS);
    n_cmp += 2;
    if (level !== 5'd16) begin n_err++; $display("FAIL overflow_level_full: got %0d want 16", level); end
    if (ov_cnt != ov0) begin n_err++; $display("FAIL overflow_early_pulse: got %0d want 0", ov_cnt - ov0); end
    send_byte(8'h10, 1'b1, BIT_CLKS);
    line_idle(1);
    n_cmp += 2;
    if (ov_cnt - ov0 != 1) begin n_err++; $display("FAIL overflow_pulse_count: got %0d want 1", ov_cnt - ov0); end
    if (level !== 5'd16) begin n_err++; $display("FAIL overflow_level_hold: got %0d want 16", level); end
    drain(to);
    n_cmp += 2;
    if (to) begin n_err++; $display("FAIL overflow_drain_timeout: got valid 1 want 0"); end
    if (got_q.size() != 16) begin n_err++; $display("FAIL overflow_drain_count: got %0d want 16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== 8'(i)) begin n_err++; $display("FAIL overflow_order[%0d]: got %h want %h", i, got_q[i], 8'(i)); end
    end
  endtask

  task automatic test_frame_err();
    int fe0, ov0;
    bit to;
    got_q.delete();
    ready = 1'b0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_byte(8'h3C, 1'b0, BIT_CLKS);
    line_idle(2);
    n_cmp += 3;
    if (fe_cnt - fe0 != 1) begin n_err++; $display("FAIL ferr_pulse: got %0d want 1", fe_cnt - fe0); end
    if (level !== 5'd0) begin n_err++; $display("FAIL ferr_level: got %0d want 0", level); end
    if (ov_cnt != ov0) begin n_err++; $display("FAIL ferr_no_overrun: got %0d want 0", ov_cnt - ov0); end
    // Stop bit low, line kept low 5 more bit times: still a single error.
    fe0 = fe_cnt;
    send_byte(8'h3C, 1'b0, BIT_CLKS);
    repeat (5 * BIT_CLKS) @(posedge clk);
    line_idle(2);
    send_byte(8'h55, 1'b1, BIT_CLKS);
    line_idle(1);
    n_cmp += 2;
    if (fe_cnt - fe0 != 1) begin n_err++; $display("FAIL ferr_held_low_count: got %0d want 1", fe_cnt - fe0); end
    if (level !== 5'd1) begin n_err++; $display("FAIL ferr_resync_level: got %0d want 1", level); end
    // True break from idle, 12 bit times long.
    fe0 = fe_cnt;
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (12 * BIT_CLKS) @(posedge clk);
    line_idle(2);
    send_byte(8'h55, 1'b1, BIT_CLKS);
    line_idle(1);
    n_cmp += 2;
    if (fe_cnt - fe0 != 1) begin n_err++; $display("FAIL ferr_break_count: got %0d want 1", fe_cnt - fe0); end
    if (level !== 5'd2) begin n_err++; $display("FAIL ferr_break_level: got %0d want 2", level); end
    drain(to);
    n_cmp += 2;
    if (got_q.size() != 2) begin n_err++; $display("FAIL ferr_drain_count: got %0d want 2", got_q.size()); end
    else if (got_q[0] !== 8'h55 || got_q[1] !== 8'h55) begin n_err++; $display("FAIL ferr_drain_data: got %h %h want 55 55", got_q[0], got_q[1]); end
    if (to) begin n_err++; $display("FAIL ferr_drain_timeout: got valid 1 want 0"); end
  endtask

  task automatic test_glitch();
    int fe0, ov0, glen;
    bit to;
    logic [7:0] b;
    got_q.delete();
    ready = 1'b0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int g = 0; g < 4; g++) begin
      glen = (g == 0) ? 12 : int'($urandom_range(4, 24));
      @(posedge clk); #1 uart_rx = 1'b0;
      repeat (glen) @(posedge clk);
      #1 uart_rx = 1'b1;
      repeat (2 * BIT_CLKS) @(posedge clk);
    end
    n_cmp += 2;
    if (level !== 5'd0) begin n_err++; $display("FAIL glitch_no_push: got level %0d want 0", level); end
    if (fe_cnt != fe0 || ov_cnt != ov0) begin n_err++; $display("FAIL glitch_no_pulse: got fe %0d ov %0d want 0/0", fe_cnt - fe0, ov_cnt - ov0); end
    b = 8'($urandom);
    send_byte(b, 1'b1, BIT_CLKS);
    line_idle(1);
    drain(to);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== b || to) begin n_err++; $display("FAIL glitch_then_byte: got %0d bytes first %h want 1 byte %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00, b); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int ov0, lvl_bad;
    bit to;
    got_q.delete();
    ready = 1'b0;
    ov0 = ov_cnt;
    lvl_bad = 0;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_byte(b, 1'b1, BIT_CLKS);
    end
    b = 8'($urandom);
    exp_q.push_back(b);
    fork
      send_byte(b, 1'b1, BIT_CLKS);
      begin
        @(posedge clk);
        repeat (PUSH_LAT - 1) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
      begin
        @(posedge clk);
        repeat (PUSH_LAT - 20) @(posedge clk);
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (level !== 5'd16) lvl_bad++;
        end
      end
    join
    line_idle(1);
    n_cmp += 3;
    if (lvl_bad != 0) begin n_err++; $display("FAIL fullpop_level_steady: got %0d off cycles want 0", lvl_bad); end
    if (ov_cnt != ov0) begin n_err++; $display("FAIL fullpop_no_overrun: got %0d want 0", ov_cnt - ov0); end
    if (level !== 5'd16) begin n_err++; $display("FAIL fullpop_level_end: got %0d want 16", level); end
    drain(to);
    n_cmp++;
    if (got_q.size() != exp_q.size() || to) begin n_err++; $display("FAIL fullpop_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL fullpop_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] partial;
    int fe0, ov0;
    bit to;
    partial = 8'h81;
    got_q.delete();
    ready = 1'b0;
    send_byte(8'h42, 1'b1, BIT_CLKS);
    line_idle(1);
    n_cmp++;
    if (level !== 5'd1) begin n_err++; $display("FAIL rstmid_preload: got level %0d want 1", level); end
    fe0 = fe_cnt; ov0 = ov_cnt;
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (BIT_CLKS) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 uart_rx = partial[i];
      repeat (BIT_CLKS) @(posedge clk);
    end
    #1 uart_rx = partial[4];
    repeat (20) @(posedge clk);
    #1 rstn = 1'b0; uart_rx = 1'b1;
    #2;
    n_cmp += 3;
    if (valid !== 1'b0 || level !== 5'd0) begin n_err++; $display("FAIL rstmid_fifo: got valid %b level %0d want 0/0", valid, level); end
    if (data !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h want 00", data); end
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL rstmid_pulses: got %b%b want 00", frame_err, overrun); end
    repeat (5) @(posedge clk);
    #1 rstn = 1'b1;
    line_idle(3);
    n_cmp += 2;
    if (level !== 5'd0) begin n_err++; $display("FAIL rstmid_discard: got level %0d want 0", level); end
    if (fe_cnt != fe0 || ov_cnt != ov0) begin n_err++; $display("FAIL rstmid_no_pulse: got fe %0d ov %0d want 0/0", fe_cnt - fe0, ov_cnt - ov0); end
    send_byte(8'h81, 1'b1, BIT_CLKS);
    line_idle(1);
    drain(to);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 8'h81 || to) begin n_err++; $display("FAIL rstmid_next_frame: got %0d bytes first %h want 1 byte 81", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00); end
  endtask

  task automatic test_baud_offset();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int bc, fe0, ov0;
    logic [7:0] fixed_b [4];
    int fixed_bc [4];
    fixed_b  = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    fixed_bc = '{62, 62, 66, 66};
    got_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i < 4) begin
        b = fixed_b[i];
        bc = fixed_bc[i];
      end else begin
        b = 8'($urandom);
        bc = int'($urandom_range(62, 66));
      end
      exp_q.push_back(b);
      send_byte(b, 1'b1, bc);
      #1 uart_rx = 1'b1;
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end
    line_idle(1);
    ready = 1'b0;
    n_cmp += 2;
    if (fe_cnt != fe0 || ov_cnt != ov0) begin n_err++; $display("FAIL baud_no_pulses: got fe %0d ov %0d want 0/0", fe_cnt - fe0, ov_cnt - ov0); end
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL baud_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL baud_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_frame_err();
    test_glitch();
    test_full_pop();
    test_reset_mid();
    test_baud_offset();
    n_cmp++;
    if (both_cnt != 0) begin n_err++; $display("FAIL pulses_exclusive: got %0d coincident cycles want 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
